decode_stage: RTL
=================

Name: decode_stage

Overview:
- Instruction-decode stage sitting directly downstream of the fetch stage. Consumes fetched pc/inst/inst_invalid.
- Decodes the 16-bit instruction and reads operands from an internal 16x16 register file with write-through bypass.
- Registers the results into the ID/EX pipeline register.
- Detects load-use hazards, drives the stall back to fetch, and converts flushed/invalid slots into bubbles.

Parameters:
- NREGS, 16, number of architectural registers; r0 reads as 0.
- DW, 16, data/pc width.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- if_pc  input  16  pc of instruction presented by fetch
- if_inst  input  16  instruction word from fetch
- if_inst_invalid  input  1  fetch slot invalid (reset cycle or redirect)
- ex_flush  input  1  branch taken in EX; squash the instruction currently in decode
- wb_en  input  1  register-file write enable
- wb_addr  input  4  write register
- wb_data  input  16  write data
- stall  output  1  combinational; fetch holds pc
- id_valid  output  1  ID/EX slot holds a real instruction
- id_pc  output  16  pc of decoded instruction
- id_opcode  output  4  inst[15:12]
- id_rd  output  4  destination register
- id_a  output  16  first operand
- id_b  output  16  second operand
- id_imm  output  16  sign-extended inst[7:0]
- id_wr_en  output  1  instruction writes rd
- id_is_load  output  1  LD
- id_is_store  output  1  ST
- id_illegal  output  1  opcode 0xA-0xF (decoded as NOP)

Behaviour:
- Fields: op = inst[15:12], rd = inst[11:8], rs = inst[7:4], rt = inst[3:0].
- Opcode decode:
  - 0x0 NOP: no reads, no write.
  - 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR: read rs, rt; write rd.
  - 0x5 LDI: no reads; write rd.
  - 0x6 LD: read rs; write rd; is_load.
  - 0x7 ST: read rs (address), rt (data); is_store.
  - 0x8 BEZ: read rd-field register as A.
  - 0x9 JMP: no reads.
  - 0xA-0xF: NOP with id_illegal=1.
- Operand A address: rs for all reads, except BEZ uses inst[11:8]. Operand B address: rt.
- Unused operands drive 0. id_imm is always sext(inst[7:0]).
- Register file:
  - 16 x 16, synchronous write at posedge when wb_en=1 and wb_addr!=0.
  - Asynchronous read.
  - Register 0 always reads 0.
  - Bypass: a read address equal to wb_addr with wb_en=1 and addr!=0 returns wb_data in the same cycle.
- Hazard detection:
  - stall = id_valid & id_is_load & id_wr_en & (rd_of_load != 0) & the current instruction uses A or B with a matching address & ~if_inst_invalid & ~ex_flush.
  - While stall=1, ID/EX loads a bubble and fetch re-presents the same instruction next cycle. The stall lasts exactly 1 cycle per load-use pair.
- ID/EX register update at every posedge:
  - if ex_flush or if_inst_invalid or stall: bubble. id_valid=0, id_wr_en=0, id_is_load=0, id_is_store=0, id_illegal=0; other fields don't-care but driven to 0.
  - else: capture the decode. id_valid=1.
- Priority: ex_flush > if_inst_invalid > stall. A flush coinciding with a hazard produces stall=0.
- Latency: 1 cycle from if_inst to id_* outputs.
- Reset (asynchronous, any time, including mid-stall): all register-file entries=0, all id_* outputs=0, id_valid=0. stall evaluates to 0 while id_valid=0.
- wb writes during reset are ignored.

Test Plan:
- Reset then ADD r3,r1,r2 with r1=5, r2=7 preloaded via wb -> next cycle id_valid=1, id_opcode=1, id_rd=3, id_a=5, id_b=7, id_wr_en=1.
- Bypass: wb_en=1, wb_addr=1, wb_data=0x00AA in the same cycle decode reads r1 -> id_a=0x00AA. wb_addr=0, wb_data=0xFFFF -> r0 still reads 0.
- Load-use: LD r4,[r1] followed by ADD r5,r4,r2 -> stall=1 for exactly one cycle, one bubble (id_valid=0), then the ADD issues with id_rd=5. LD r4 followed by ADD r5,r6,r2 -> no stall.
- Flush: ex_flush=1 while a hazard is pending -> stall=0, id_valid=0 next cycle. if_inst_invalid=1 -> bubble.
- Immediates/illegal: LDI r2,0x80 -> id_imm=0xFF80, id_wr_en=1. Opcode 0xC -> id_illegal=1, id_wr_en=0, id_valid=1.
- Async reset asserted mid-stall -> all outputs 0 and stall=0 immediately, without waiting for a clock edge. Register file reads 0 after release.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: instruction-decode stage sitting directly behind fetch.
// Decodes the 16-bit instruction, reads operands from a 16x16 register file
// with write-through bypass, and registers the result into the ID/EX register.
// A load-use hazard raises a one-cycle stall. Flushed, invalid and stalled
// slots enter ID/EX as bubbles.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   if_pc/if_inst       pc and instruction word presented by fetch
//   if_inst_invalid     fetch slot carries no instruction
//   ex_flush            branch taken in EX; squash the instruction in decode
//   wb_en/addr/data     register-file write port, bypassed to the reads
//   stall               combinational; fetch holds its pc
//   id_*                ID/EX pipeline register contents
module decode_stage #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] if_pc,
  input  logic [15:0]   if_inst,
  input  logic          if_inst_invalid,
  input  logic          ex_flush,
  input  logic          wb_en,
  input  logic [3:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          stall,
  output logic          id_valid,
  output logic [DW-1:0] id_pc,
  output logic [3:0]    id_opcode,
  output logic [3:0]    id_rd,
  output logic [DW-1:0] id_a,
  output logic [DW-1:0] id_b,
  output logic [DW-1:0] id_imm,
  output logic          id_wr_en,
  output logic          id_is_load,
  output logic          id_is_store,
  output logic          id_illegal
);

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpAnd = 4'h3;
  localparam logic [3:0] OpOr  = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpLd  = 4'h6;
  localparam logic [3:0] OpSt  = 4'h7;
  localparam logic [3:0] OpBez = 4'h8;
  localparam logic [3:0] OpJmp = 4'h9;

  // Instruction fields
  logic [3:0] op, rd, rs, rt;
  assign op = if_inst[15:12];
  assign rd = if_inst[11:8];
  assign rs = if_inst[7:4];
  assign rt = if_inst[3:0];

  // Decode
  logic       uses_a, uses_b, wr_en, is_load, is_store, illegal;
  logic [3:0] a_addr;

  always_comb begin
    uses_a   = 1'b0;
    uses_b   = 1'b0;
    a_addr   = rs;
    wr_en    = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    illegal  = 1'b0;
    case (op)
      OpAdd, OpSub, OpAnd, OpOr: begin
        uses_a = 1'b1;
        uses_b = 1'b1;
        wr_en  = 1'b1;
      end
      OpLdi: wr_en = 1'b1;
      OpLd: begin
        uses_a  = 1'b1;
        wr_en   = 1'b1;
        is_load = 1'b1;
      end
      OpSt: begin
        uses_a   = 1'b1;
        uses_b   = 1'b1;
        is_store = 1'b1;
      end
      OpBez: begin
        uses_a = 1'b1;
        a_addr = rd;  // branch tests the register named in the rd field
      end
      OpNop, OpJmp: ;
      default: illegal = 1'b1;
    endcase
  end

  // Register file; r0 is never written so it stays zero.
  logic [DW-1:0] rf_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en && (wb_addr != 4'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Asynchronous reads with write-through bypass from the write port
  logic [DW-1:0] a_rd, b_rd, a_val, b_val;
  assign a_rd = (a_addr == 4'd0) ? '0 :
                (wb_en && (wb_addr == a_addr)) ? wb_data : rf_q[a_addr];
  assign b_rd = (rt == 4'd0) ? '0 :
                (wb_en && (wb_addr == rt)) ? wb_data : rf_q[rt];
  assign a_val = uses_a ? a_rd : '0;
  assign b_val = uses_b ? b_rd : '0;

  // ID/EX register
  logic          id_valid_q, id_wr_en_q, id_is_load_q, id_is_store_q, id_illegal_q;
  logic [DW-1:0] id_pc_q, id_a_q, id_b_q, id_imm_q;
  logic [3:0]    id_opcode_q, id_rd_q;

  // Load-use hazard: the load in ID/EX has not produced data yet, so the
  // dependent instruction waits one cycle. Flush and invalid slots win.
  logic src_hit, bubble;
  assign src_hit = (uses_a && (a_addr == id_rd_q)) || (uses_b && (rt == id_rd_q));
  assign stall   = id_valid_q && id_is_load_q && id_wr_en_q && (id_rd_q != 4'd0) &&
                   src_hit && !if_inst_invalid && !ex_flush;
  assign bubble  = ex_flush || if_inst_invalid || stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_opcode_q   <= '0;
      id_rd_q       <= '0;
      id_a_q        <= '0;
      id_b_q        <= '0;
      id_imm_q      <= '0;
      id_wr_en_q    <= 1'b0;
      id_is_load_q  <= 1'b0;
      id_is_store_q <= 1'b0;
      id_illegal_q  <= 1'b0;
    end else if (bubble) begin
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_opcode_q   <= '0;
      id_rd_q       <= '0;
      id_a_q        <= '0;
      id_b_q        <= '0;
      id_imm_q      <= '0;
      id_wr_en_q    <= 1'b0;
      id_is_load_q  <= 1'b0;
      id_is_store_q <= 1'b0;
      id_illegal_q  <= 1'b0;
    end else begin
      id_valid_q    <= 1'b1;
      id_pc_q       <= if_pc;
      id_opcode_q   <= op;
      id_rd_q       <= rd;
      id_a_q        <= a_val;
      id_b_q        <= b_val;
      id_imm_q      <= {{(DW-8){if_inst[7]}}, if_inst[7:0]};
      id_wr_en_q    <= wr_en;
      id_is_load_q  <= is_load;
      id_is_store_q <= is_store;
      id_illegal_q  <= illegal;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_opcode   = id_opcode_q;
  assign id_rd       = id_rd_q;
  assign id_a        = id_a_q;
  assign id_b        = id_b_q;
  assign id_imm      = id_imm_q;
  assign id_wr_en    = id_wr_en_q;
  assign id_is_load  = id_is_load_q;
  assign id_is_store = id_is_store_q;
  assign id_illegal  = id_illegal_q;

endmodule
